// File: rtl/tdc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tdc_ctrl_pkg
// Shared definitions for the TDC measurement sequencer:
//   - TDC result widths and the derived sample / sum widths
//   - FSM state encoding
//   - coarse overflow detect and saturate-to-sample conversion
// -----------------------------------------------------------------------------
package tdc_ctrl_pkg;

  localparam int COARSE_W          = 32;
  localparam int FINE_W            = 9;
  localparam int SAMPLE_LSB_COARSE = 15;
  localparam int SAMPLE_W          = SAMPLE_LSB_COARSE + FINE_W;
  // 255 samples of the largest value still fit without wrapping.
  localparam int SUM_W             = SAMPLE_W + 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS,
    ST_CAPT,
    ST_DONE
  } state_t;

  // Any coarse bit above the kept field means the sample cannot be represented.
  function automatic logic coarse_ovf(input logic [COARSE_W-1:0] coarse);
    return |coarse[COARSE_W-1:SAMPLE_LSB_COARSE];
  endfunction

  function automatic logic [SAMPLE_W-1:0] sat_sample(
    input logic [COARSE_W-1:0] coarse,
    input logic [FINE_W-1:0]   fine
  );
    if (coarse_ovf(coarse)) begin
      return '1;
    end
    return {coarse[SAMPLE_LSB_COARSE-1:0], fine};
  endfunction

endpackage

// File: rtl/tdc_stats_accum.sv
// -----------------------------------------------------------------------------
// tdc_stats_accum
// Running statistics over captured TDC samples.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          restart statistics (min to all-ones, everything else to 0)
//   upd          fold 'sample' into last/min/max/sum
//   sample       saturated sample
//   last_sample  most recent sample
//   min_sample   smallest sample since clr
//   max_sample   largest sample since clr
//   sum_sample   sum of samples since clr
// -----------------------------------------------------------------------------
module tdc_stats_accum
  import tdc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                upd,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] last_sample,
  output logic [SAMPLE_W-1:0] min_sample,
  output logic [SAMPLE_W-1:0] max_sample,
  output logic [SUM_W-1:0]    sum_sample
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sample <= '0;
      min_sample  <= '1;
      max_sample  <= '0;
      sum_sample  <= '0;
    end else if (clr) begin
      last_sample <= '0;
      min_sample  <= '1;
      max_sample  <= '0;
      sum_sample  <= '0;
    end else if (upd) begin
      last_sample <= sample;
      if (sample < min_sample) begin
        min_sample <= sample;
      end
      if (sample > max_sample) begin
        max_sample <= sample;
      end
      sum_sample <= sum_sample + SUM_W'(sample);
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_meas_ctrl
// Measurement sequencer for the on-chip TDC. Arms the TDC for cfg_count
// start/stop measurements, applies a per-phase timeout and keeps statistics.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, abort                single-cycle run control pulses
//   cfg_count, cfg_timeout      run configuration, latched on accepted start
//   tdc_busy/coarse/fine        TDC status and result
//   tdc_arm                     enables the TDC start input gate
//   busy, done                  run in progress / sticky run finished
//   err_timeout/ovf/cfg         sticky error flags
//   meas_cnt                    measurements completed in current/last run
//   last/min/max/sum_sample     statistics
// -----------------------------------------------------------------------------
module tdc_meas_ctrl
  import tdc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          cfg_count,
  input  logic [15:0]         cfg_timeout,
  input  logic                tdc_busy,
  input  logic [COARSE_W-1:0] tdc_coarse,
  input  logic [FINE_W-1:0]   tdc_fine,
  output logic                tdc_arm,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic                err_ovf,
  output logic                err_cfg,
  output logic [7:0]          meas_cnt,
  output logic [SAMPLE_W-1:0] last_sample,
  output logic [SAMPLE_W-1:0] min_sample,
  output logic [SAMPLE_W-1:0] max_sample,
  output logic [SUM_W-1:0]    sum_sample
);

  state_t        state_reg;
  logic [7:0]    count_reg;
  logic [15:0]   timeout_reg;
  logic [15:0]   phase_cnt_reg;

  logic                accept_start;
  logic                capture;
  logic                timeout_hit;
  logic [7:0]          meas_cnt_inc;
  logic [SAMPLE_W-1:0] sample;

  // abort also suppresses a start seen in the same cycle.
  assign accept_start = (state_reg == ST_IDLE) && start && !abort && (cfg_count != 8'd0);
  assign capture      = (state_reg == ST_CAPT) && !abort;
  // Phase counter holds the number of cycles spent in the phase, including
  // the current one, so the exit decision lands cfg_timeout cycles in.
  assign timeout_hit  = (timeout_reg != 16'd0) && (phase_cnt_reg == timeout_reg);
  assign meas_cnt_inc = meas_cnt + 8'd1;
  assign sample       = sat_sample(tdc_coarse, tdc_fine);

  tdc_stats_accum u_stats (
    .clk         (clk),
    .rst         (rst),
    .clr         (accept_start),
    .upd         (capture),
    .sample      (sample),
    .last_sample (last_sample),
    .min_sample  (min_sample),
    .max_sample  (max_sample),
    .sum_sample  (sum_sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      timeout_reg   <= '0;
      phase_cnt_reg <= '0;
      tdc_arm       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      err_ovf       <= 1'b0;
      err_cfg       <= 1'b0;
      meas_cnt      <= '0;
    end else if (abort && (state_reg != ST_IDLE)) begin
      state_reg <= ST_IDLE;
      tdc_arm   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept_start) begin
            count_reg     <= cfg_count;
            timeout_reg   <= cfg_timeout;
            phase_cnt_reg <= 16'd1;
            meas_cnt      <= '0;
            done          <= 1'b0;
            err_timeout   <= 1'b0;
            err_ovf       <= 1'b0;
            err_cfg       <= 1'b0;
            busy          <= 1'b1;
            tdc_arm       <= 1'b1;
            state_reg     <= ST_ARM;
          end else if (start && !abort) begin
            err_cfg <= 1'b1;
          end
        end
        ST_ARM: begin
          if (timeout_hit) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            tdc_arm     <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (tdc_busy) begin
            // Level check: busy already high on entry counts as the rise.
            tdc_arm       <= 1'b0;
            phase_cnt_reg <= 16'd1;
            state_reg     <= ST_MEAS;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 16'd1;
          end
        end
        ST_MEAS: begin
          if (timeout_hit) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (!tdc_busy) begin
            state_reg <= ST_CAPT;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 16'd1;
          end
        end
        ST_CAPT: begin
          meas_cnt <= meas_cnt_inc;
          if (coarse_ovf(tdc_coarse)) begin
            err_ovf <= 1'b1;
          end
          if (meas_cnt_inc == count_reg) begin
            state_reg <= ST_DONE;
          end else begin
            tdc_arm       <= 1'b1;
            phase_cnt_reg <= 16'd1;
            state_reg     <= ST_ARM;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the on-chip TDC. It arms the TDC for a programmed number of start/stop measurements and applies a per-phase timeout. For each completed measurement it captures the coarse/fine result and keeps running min/max/sum statistics. It sits between the SPI config/status register banks and the `tdc` instance: config registers drive its control inputs, and its outputs replace the raw coarse/fine words in the status bank.

## Interface
- `COARSE_W`, 32, coarse counter width from TDC
- `FINE_W`, 9, fine (delay-line) result width from TDC
- `SAMPLE_LSB_COARSE`, 15, coarse bits kept in a sample; sample width `SAMPLE_W = SAMPLE_LSB_COARSE + FINE_W` (24)
- `clk`  in  1  system clock, the only clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle pulse: begin a run
- `abort`  in  1  single-cycle pulse: terminate a run
- `cfg_count`  in  8  measurements per run; 0 = reject start
- `cfg_timeout`  in  16  max clk cycles per phase; 0 = no timeout
- `tdc_busy`  in  1  TDC busy flag (synchronous to `clk`)
- `tdc_coarse`  in  COARSE_W  TDC coarse result
- `tdc_fine`  in  FINE_W  TDC fine result
- `tdc_arm`  out  1  enables the TDC start input gate
- `busy`  out  1  run in progress
- `done`  out  1  sticky: run finished; cleared by next accepted `start`
- `err_timeout`, `err_ovf`, `err_cfg`  out  1 each  sticky error flags
- `meas_cnt`  out  8  measurements completed in current/last run
- `last_sample`, `min_sample`, `max_sample`  out  SAMPLE_W  statistics
- `sum_sample`  out  SAMPLE_W+8  accumulated sum

## Operation
- Sample = `{tdc_coarse[SAMPLE_LSB_COARSE-1:0], tdc_fine}`. If any higher coarse bit is set, the sample saturates to all-ones and `err_ovf` sets.
- FSM states:
  - IDLE: `start` with `cfg_count`≠0 latches count/timeout, clears stats/flags/`meas_cnt`, sets `min_sample`=all-ones and `max_sample`=0, then goes to ARM. `start` with `cfg_count`=0 sets `err_cfg` only.
  - ARM: `tdc_arm`=1; waits for `tdc_busy` rising → MEAS.
  - MEAS: `tdc_arm`=0; waits for `tdc_busy`=0 → CAPT.
  - CAPT (1 cycle): sample the result, update last/min/max/sum, increment `meas_cnt`. If `meas_cnt`+1 == latched count → DONE, else → ARM.
  - DONE (1 cycle): set `done` → IDLE.
- Timeout:
  - Phase counter resets on entry to ARM and to MEAS.
  - Reaching the latched timeout (when nonzero) sets `err_timeout`, sets `done` and returns to IDLE. Stats keep the completed measurements.
- `abort` in any non-IDLE state returns to IDLE next cycle, with `tdc_arm`=0 and `done`=1. `abort` wins over `start`, capture and timeout in the same cycle.
- `start` while not IDLE is ignored.
- `cfg_*` changes mid-run have no effect; the values are latched at start.

## Timing
- Reset: FSM=IDLE, all outputs 0, except `min_sample`=all-ones.
- `start` at cycle N → `busy`=1 and `tdc_arm`=1 at N+1.
- `tdc_busy` rise seen at cycle M → `tdc_arm`=0 at M+1.
- `tdc_busy` falls at cycle K → CAPT at K+1, stats visible at K+2.
- Final capture at cycle C → `done`=1 at C+2, and `busy`=0 at the same time.
- Timeout fires when the phase counter equals `cfg_timeout`, i.e. `cfg_timeout` cycles after phase entry. Flags update the following cycle.
- Busy already high on entry to ARM: treated as a rise after one cycle (no lost measurement).
- Sum cannot wrap: 255 × max sample fits in SAMPLE_W+8.

## Structure
- Package `tdc_ctrl_pkg`: state enum (IDLE, ARM, MEAS, CAPT, DONE), `SAMPLE_W` derivation, and the saturate-to-sample function.
- Sub-module `tdc_stats_accum`: clear/update inputs plus sample in; last/min/max/sum out.
- The top of this block holds the FSM, phase counter and measurement counter.

## Test plan
- `cfg_count`=3, timeout 0, three busy pulses with samples 0x000100, 0x000050, 0x000200 → `meas_cnt`=3, min=0x50, max=0x200, sum=0x350, `done`=1, no errors.
- `cfg_timeout`=10, no busy pulse → `err_timeout`=1 and `done`=1 exactly 11 cycles after `start`, `meas_cnt`=0, `tdc_arm`=0.
- Coarse=0x8000, fine=5 → sample=0xFFFFFF, `err_ovf`=1.
- `abort` during MEAS of the 2nd of 4 → IDLE next cycle, `meas_cnt`=1, `done`=1; a subsequent `start` clears all flags.
- `start` with `cfg_count`=0 → `err_cfg`=1, `busy` stays 0.
- `rst` asserted mid-MEAS → all outputs return to reset values asynchronously, with no capture.
